// File: rtl/int_to_fp_pipe.sv
// int_to_fp_pipe: three-stage integer to floating-point converter.
// Stage 1 takes the sign and magnitude, stage 2 normalises and computes the
// exponent, and stage 3 rounds and handles overflow. The whole pipe moves on
// one enable, so a stalled output freezes every stage and bubbles stay in place.
module int_to_fp_pipe #(
    parameter int INT_W = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INT_W-1:0]       in_int,
    input  logic                   in_signed,
    input  logic [1:0]             in_rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_fp,
    output logic                   out_inexact,
    output logic                   out_overflow
);

    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int LZ_W  = $clog2(INT_W + 1);
    // Fraction bits below the hidden one, followed by room for guard and sticky.
    localparam int EXT_W = INT_W + MAN_W + 1;
    localparam logic [EXP_W-1:0] EXP_MAX    = '1;
    localparam logic [EXP_W-1:0] EXP_MAXFIN = {{(EXP_W-1){1'b1}}, 1'b0};

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    // The largest normalised exponent must fit below the all-ones code.
    generate
        if (BIAS < INT_W - 1) begin : g_exp_too_narrow
            $error("int_to_fp_pipe: EXP_W is too narrow for INT_W");
        end
        if (INT_W < 8 || INT_W > 64) begin : g_int_w_range
            $error("int_to_fp_pipe: INT_W must lie in 8..64");
        end
    endgenerate

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- stage 1: sign and magnitude ----------------
    logic             sign_in;
    logic [INT_W-1:0] mag_in;
    assign sign_in = in_signed & in_int[INT_W-1];
    // Negating the most negative value gives 2^(INT_W-1), which fits unsigned.
    assign mag_in  = sign_in ? -in_int : in_int;

    logic             s1_valid_reg;
    logic             s1_sign_reg;
    logic [INT_W-1:0] s1_mag_reg;
    logic [1:0]       s1_rm_reg;

    // Capture the operand sign, magnitude and rounding mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_mag_reg   <= '0;
            s1_rm_reg    <= RM_RNE;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            s1_sign_reg  <= sign_in;
            s1_mag_reg   <= mag_in;
            s1_rm_reg    <= in_rm;
        end
    end

    // ---------------- stage 2: normalisation ----------------
    logic [LZ_W-1:0]  lzc;
    logic [INT_W-1:0] norm;
    logic [EXP_W-1:0] exp_next;

    // Leading-zero count: the highest set bit wins because it is visited last.
    always_comb begin
        lzc = LZ_W'(INT_W);
        for (int i = 0; i < INT_W; i++) begin
            if (s1_mag_reg[i]) begin
                lzc = LZ_W'(INT_W - 1 - i);
            end
        end
    end

    assign norm     = s1_mag_reg << lzc;
    // Meaningless for a zero operand; the zero flag overrides it later.
    assign exp_next = EXP_W'(BIAS + INT_W - 1 - int'(lzc));

    logic             s2_valid_reg;
    logic             s2_sign_reg;
    logic [INT_W-2:0] s2_frac_reg;
    logic [EXP_W-1:0] s2_exp_reg;
    logic             s2_zero_reg;
    logic [1:0]       s2_rm_reg;

    // Register the normalised fraction (hidden bit dropped) and exponent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_reg <= 1'b0;
            s2_sign_reg  <= 1'b0;
            s2_frac_reg  <= '0;
            s2_exp_reg   <= '0;
            s2_zero_reg  <= 1'b0;
            s2_rm_reg    <= RM_RNE;
        end else if (adv) begin
            s2_valid_reg <= s1_valid_reg;
            s2_sign_reg  <= s1_sign_reg;
            s2_frac_reg  <= norm[INT_W-2:0];
            s2_exp_reg   <= exp_next;
            // After normalisation only a zero operand lacks a leading one.
            s2_zero_reg  <= !norm[INT_W-1];
            s2_rm_reg    <= s1_rm_reg;
        end
    end

    // ---------------- stage 3: rounding ----------------
    logic [EXT_W-1:0]     ext;
    logic [MAN_W-1:0]     frac;
    logic                 guard;
    logic                 sticky;
    logic                 inc;
    logic                 to_inf;
    logic [MAN_W:0]       mant_sum;
    logic [EXP_W-1:0]     exp_r;
    logic                 ovf;
    logic [EXP_W+MAN_W:0] fp_next;

    // When INT_W-1 <= MAN_W the padding zeros make guard and sticky zero.
    assign ext    = {s2_frac_reg, {(MAN_W+2){1'b0}}};
    assign frac   = ext[EXT_W-1 -: MAN_W];
    assign guard  = ext[EXT_W-1-MAN_W];
    assign sticky = |ext[EXT_W-2-MAN_W:0];

    // Rounding increment and overflow saturation direction per mode.
    always_comb begin
        inc    = 1'b0;
        to_inf = 1'b1;
        case (s2_rm_reg)
            RM_RNE: begin
                inc    = guard && (sticky || frac[0]);
                to_inf = 1'b1;
            end
            RM_RTZ: begin
                inc    = 1'b0;
                to_inf = 1'b0;
            end
            RM_RUP: begin
                inc    = !s2_sign_reg && (guard || sticky);
                to_inf = !s2_sign_reg;
            end
            RM_RDN: begin
                inc    = s2_sign_reg && (guard || sticky);
                to_inf = s2_sign_reg;
            end
            default: begin
                inc    = 1'b0;
                to_inf = 1'b1;
            end
        endcase
    end

    // A carry out means the fraction was all ones; the renormalised fraction
    // is then all zeros, which is exactly what the low sum bits already hold.
    assign mant_sum = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    assign exp_r    = s2_exp_reg + {{(EXP_W-1){1'b0}}, mant_sum[MAN_W]};
    assign ovf      = (exp_r == EXP_MAX);

    // Assemble the result: zero, saturated overflow, or the rounded value.
    always_comb begin
        fp_next = {s2_sign_reg, exp_r, mant_sum[MAN_W-1:0]};
        if (s2_zero_reg) begin
            fp_next = '0;
        end else if (ovf) begin
            if (to_inf) begin
                fp_next = {s2_sign_reg, EXP_MAX, {MAN_W{1'b0}}};
            end else begin
                fp_next = {s2_sign_reg, EXP_MAXFIN, {MAN_W{1'b1}}};
            end
        end
    end

    logic                 out_valid_reg;
    logic [EXP_W+MAN_W:0] out_fp_reg;
    logic                 out_inexact_reg;
    logic                 out_overflow_reg;

    // Output register; holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg    <= 1'b0;
            out_fp_reg       <= '0;
            out_inexact_reg  <= 1'b0;
            out_overflow_reg <= 1'b0;
        end else if (adv) begin
            out_valid_reg    <= s2_valid_reg;
            out_fp_reg       <= fp_next;
            out_inexact_reg  <= !s2_zero_reg && (guard || sticky || ovf);
            out_overflow_reg <= !s2_zero_reg && ovf;
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_fp       = out_fp_reg;
    assign out_inexact  = out_inexact_reg;
    assign out_overflow = out_overflow_reg;

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Testbench for int_to_fp_pipe: a binary32-style instance (a) and a
// half-precision-style instance (b). Expected results are queued when an
// operand is accepted and compared when the result is consumed.
module tb_int_to_fp_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
    logic        a_out_inexact, a_out_overflow;
    logic [31:0] a_in_int, a_out_fp;
    logic [1:0]  a_in_rm;

    logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
    logic        b_out_inexact, b_out_overflow;
    logic [15:0] b_in_int, b_out_fp;
    logic [1:0]  b_in_rm;

    int_to_fp_pipe #(.INT_W(32), .EXP_W(8), .MAN_W(23)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_int(a_in_int),
        .in_signed(a_in_signed), .in_rm(a_in_rm),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_fp(a_out_fp),
        .out_inexact(a_out_inexact), .out_overflow(a_out_overflow)
    );

    int_to_fp_pipe #(.INT_W(16), .EXP_W(5), .MAN_W(10)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_int(b_in_int),
        .in_signed(b_in_signed), .in_rm(b_in_rm),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_fp(b_out_fp),
        .out_inexact(b_out_inexact), .out_overflow(b_out_overflow)
    );

    typedef struct packed {
        logic [31:0] fp;
        logic        inx;
        logic        ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   a_pops   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] fp, input logic inx, input logic ovf);
        exp_t r;
        r.fp  = fp;
        r.inx = inx;
        r.ovf = ovf;
        return r;
    endfunction

    // Reference conversion: round by comparing the discarded remainder with half an ulp.
    function automatic exp_t model(input int iw, input int ew, input int mw,
                                   input logic [63:0] raw, input logic sg, input logic [1:0] rm);
        exp_t        r;
        logic [63:0] val, mag, q, rem, half;
        logic        s, inc, inx, to_inf;
        int          p, sh, e;
        r   = '0;
        val = raw & ((64'd1 << iw) - 64'd1);
        s   = sg & val[iw-1];
        mag = s ? ((64'd1 << iw) - val) : val;
        if (mag == 64'd0) return r;
        p = 63;
        while (!mag[p]) p--;
        inc = 1'b0;
        inx = 1'b0;
        rem = '0;
        if (p <= mw) begin
            q = mag << (mw - p);
        end else begin
            sh   = p - mw;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 64'd0);
            case (rm)
                2'd0:    inc = (rem > half) || ((rem == half) && q[0]);
                2'd1:    inc = 1'b0;
                2'd2:    inc = !s && inx;
                default: inc = s && inx;
            endcase
        end
        q = q + 64'(inc);
        if (q >= (64'd2 << mw)) begin
            q = q >> 1;
            p++;
        end
        e = ((1 << (ew - 1)) - 1) + p;
        if (e >= (1 << ew) - 1) begin
            inx    = 1'b1;
            r.ovf  = 1'b1;
            to_inf = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
            if (to_inf)
                r.fp = 32'((64'(s) << (ew + mw)) | (64'((1 << ew) - 1) << mw));
            else
                r.fp = 32'((64'(s) << (ew + mw)) | (64'((1 << ew) - 2) << mw) | ((64'd1 << mw) - 64'd1));
        end else begin
            r.fp = 32'((64'(s) << (ew + mw)) | (64'(e) << mw) | (q & ((64'd1 << mw) - 64'd1)));
        end
        r.inx = inx;
        return r;
    endfunction

    // Present one operand from a negedge until accepted; queue its expectation.
    task automatic send(input int which, input logic [31:0] v, input logic sg,
                        input logic [1:0] rm, input exp_t e);
        bit done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (which == 0) begin
                a_in_valid = 1'b1; a_in_int = v; a_in_signed = sg; a_in_rm = rm;
            end else begin
                b_in_valid = 1'b1; b_in_int = v[15:0]; b_in_signed = sg; b_in_rm = rm;
            end
            #1;
            if ((which == 0) ? a_in_ready : b_in_ready) begin
                if (which == 0) qa.push_back(e);
                else            qb.push_back(e);
                done = 1'b1;
            end
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        if (!done) check_val("accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic send_m(input int which, input logic [31:0] v, input logic sg, input logic [1:0] rm);
        exp_t e;
        if (which == 0) e = model(32, 8, 23, {32'd0, v}, sg, rm);
        else            e = model(16, 5, 10, {48'd0, v[15:0]}, sg, rm);
        send(which, v, sg, rm, e);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (qa.size() + qb.size()) != 0; k++) @(negedge clk);
        check_val("drain_empty", 64'(qa.size() + qb.size()), 64'd0);
    endtask

    task automatic pop_check(input int which, input logic ov, input logic [31:0] fp,
                             input logic inx, input logic ovf);
        exp_t  e;
        string t = (which == 0) ? "a" : "b";
        if (((which == 0) ? qa.size() : qb.size()) == 0) begin
            check_val({t, "_spurious_out"}, 64'(ov), 64'd0);
            return;
        end
        if (which == 0) begin
            e = qa.pop_front();
            a_pops++;
        end else begin
            e = qb.pop_front();
        end
        check_val({t, "_fp"}, 64'(fp), 64'(e.fp));
        check_val({t, "_inexact"}, 64'(inx), 64'(e.inx));
        check_val({t, "_overflow"}, 64'(ovf), 64'(e.ovf));
        $display("%s result fp=0x%0h inexact=%0b overflow=%0b", t, fp, inx, ovf);
    endtask

    // Output monitor: samples between edges, when a consume is settled.
    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            if (a_out_valid && a_out_ready) pop_check(0, a_out_valid, a_out_fp, a_out_inexact, a_out_overflow);
            if (b_out_valid && b_out_ready) pop_check(1, b_out_valid, {16'd0, b_out_fp}, b_out_inexact, b_out_overflow);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        bit   seen;
        int   c0;
        logic [31:0] v4;
        reset = 1'b0;
        a_in_valid = 1'b0; a_in_int = '0; a_in_signed = 1'b0; a_in_rm = 2'd0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_int = '0; b_in_signed = 1'b0; b_in_rm = 2'd0; b_out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check_val("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check_val("rst_a_out_fp", 64'(a_out_fp), 64'd0);
        check_val("rst_a_flags", 64'({a_out_inexact, a_out_overflow}), 64'd0);
        check_val("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        @(negedge clk);

        // Latency: count edges from the accepting edge to out_valid.
        send(0, 32'hFFFFF884, 1'b1, 2'd0, mk(32'hC4EF8000, 1'b0, 1'b0));
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            #1;
            if (a_out_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check_val("latency", 64'(lat), 64'd3);
        @(negedge clk);

        // Directed rounding, tie, extreme and zero cases.
        send(0, 32'hFFFFFFFF, 1'b0, 2'd0, mk(32'h4F800000, 1'b1, 1'b0));
        send(0, 32'hFFFFFFFF, 1'b0, 2'd1, mk(32'h4F7FFFFF, 1'b1, 1'b0));
        send(0, 32'h80000000, 1'b1, 2'd0, mk(32'hCF000000, 1'b0, 1'b0));
        send(0, 32'h01000001, 1'b0, 2'd0, mk(32'h4B800000, 1'b1, 1'b0));
        send(0, 32'h01000001, 1'b0, 2'd2, mk(32'h4B800001, 1'b1, 1'b0));
        send(0, 32'h01000001, 1'b0, 2'd3, mk(32'h4B800000, 1'b1, 1'b0));
        send(0, 32'h01000003, 1'b0, 2'd0, mk(32'h4B800002, 1'b1, 1'b0));
        send(0, 32'h00000000, 1'b0, 2'd0, mk(32'h00000000, 1'b0, 1'b0));
        send(0, 32'h00000000, 1'b1, 2'd3, mk(32'h00000000, 1'b0, 1'b0));
        send(0, 32'hFFFFFFFF, 1'b1, 2'd3, mk(32'hBF800000, 1'b0, 1'b0));
        drain();

        // Back-to-back stream of 8: results must emerge on 8 consecutive cycles.
        c0 = a_pops;
        for (int i = 0; i < 8; i++)
            send_m(0, $urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        repeat (2) @(negedge clk);
        #3;
        check_val("stream_consecutive", 64'(a_pops - c0), 64'd8);
        @(negedge clk);
        drain();

        // Backpressure: fill the pipe with the consumer stalled.
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_m(0, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        v4 = $urandom;
        a_in_valid = 1'b1; a_in_int = v4; a_in_signed = 1'b1; a_in_rm = 2'd2;
        #1;
        check_val("bp_out_valid", 64'(a_out_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check_val("bp_in_ready", 64'(a_in_ready), 64'd0);
            check_val("bp_hold_fp", 64'(a_out_fp), 64'(qa[0].fp));
        end
        @(negedge clk);
        a_out_ready = 1'b1;
        send_m(0, v4, 1'b1, 2'd2);
        drain();

        // Mixed random traffic on the wide instance, including edge values.
        send_m(0, 32'h7FFFFFFF, 1'b1, 2'd0);
        send_m(0, 32'h00FFFFFF, 1'b0, 2'd2);
        send_m(0, 32'h00000001, 1'b1, 2'd3);
        for (int i = 0; i < 12; i++)
            send_m(0, $urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        drain();

        // Narrow instance: overflow behaviour and random traffic.
        send(1, 32'h0000FFFF, 1'b0, 2'd0, mk(32'h00007C00, 1'b1, 1'b1));
        send(1, 32'h0000FFFF, 1'b0, 2'd1, mk(32'h00007BFF, 1'b1, 1'b0));
        send(1, 32'h0000FFFF, 1'b0, 2'd2, mk(32'h00007C00, 1'b1, 1'b1));
        for (int i = 0; i < 8; i++)
            send_m(1, $urandom & 32'hFFFF, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        drain();

        // Reset in the middle of a stream discards every in-flight operand.
        for (int i = 0; i < 4; i++)
            send_m(1, $urandom & 32'hFFFF, 1'b0, 2'($urandom_range(0, 3)));
        #3;
        reset = 1'b0;
        #1;
        check_val("midrst_b_out_valid", 64'(b_out_valid), 64'd0);
        check_val("midrst_b_out_fp", 64'(b_out_fp), 64'd0);
        qa.delete();
        qb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check_val("post_rst_b_out_valid", 64'(b_out_valid), 64'd0);
        check_val("post_rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check_val("post_rst_b_in_ready", 64'(b_in_ready), 64'd1);
        @(negedge clk);
        send(1, 32'h0000FFFF, 1'b0, 2'd1, mk(32'h00007BFF, 1'b1, 1'b0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_to_fp_pipe.md
Name: int_to_fp_pipe

Overview:
Parametrised, pipelined successor to the single-format int_to_fp converter. It converts a signed or unsigned INT_W-bit integer to an IEEE-754-style float with EXP_W exponent bits and MAN_W fraction bits. It supports four rounding modes, raises inexact and overflow flags, and uses a valid/ready handshake so it can sit between an issue stage and the FPU writeback without external stall logic.

Parameters:
INT_W, 32, integer input width; legal range 8..64.
EXP_W, 8, output exponent width; 2^(EXP_W-1)-1 >= INT_W-1 is required (elaboration-time check).
MAN_W, 23, output fraction width (hidden bit excluded).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  input operand valid.
in_ready  output  1  converter can accept an operand this cycle.
in_int  input  INT_W  integer operand.
in_signed  input  1  1 = two's-complement operand, 0 = unsigned.
in_rm  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf).
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_fp  output  1+EXP_W+MAN_W  {sign, biased exponent, fraction}.
out_inexact  output  1  result differs from the exact integer value.
out_overflow  output  1  rounded magnitude exceeds the largest finite value.

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits, out_fp, out_inexact and out_overflow go to 0. in_ready reads 1 once reset is released. Reset asserted mid-operation discards all in-flight operands, and no result is emitted for them.
- Handshake: a transfer occurs when in_valid && in_ready. A result is consumed when out_valid && out_ready. in_ready = !out_valid || out_ready, so the whole pipe advances on a global enable. Bubbles are carried as invalid stages. Full throughput is one operand per cycle.
- While out_valid=1 and out_ready=0, out_fp, out_inexact and out_overflow hold stable, and no stage advances.
- Latency: 3 cycles from accepted input to out_valid, with out_ready held at 1.
- Stage 1: sign = in_signed & in_int[INT_W-1]. Take the magnitude as a two's-complement negation when sign=1. The magnitude is INT_W bits, so -2^(INT_W-1) is representable. Register sign, magnitude and rm.
- Stage 2: leading-zero count of the magnitude. Left-normalise so the MSB is 1. Register the shifted value, exponent = bias + (INT_W-1-lzc) with bias = 2^(EXP_W-1)-1, and a zero flag.
- Stage 3 rounding:
  - When INT_W-1 > MAN_W: guard is the bit below the LSB, sticky is the OR of the remaining bits; otherwise the result is exact.
  - RNE: increment when guard && (sticky || lsb).
  - RTZ: never increment.
  - RUP: increment when !sign && (guard || sticky).
  - RDN: increment when sign && (guard || sticky).
  - Mantissa carry-out shifts the mantissa right by one and increments the exponent.
  - inexact = guard || sticky.
- Overflow: overflow when the exponent reaches 2^EXP_W-1 after rounding. Result:
  - RNE: ±inf.
  - RTZ: ±max-finite.
  - RUP: +inf if positive, -max-finite if negative.
  - RDN: -inf if negative, +max-finite if positive.
  - out_overflow=1 and out_inexact=1.
- Zero input: out_fp = all zeros (+0, in every rounding mode), with both flags 0.
- Simultaneous accept and drain in the same cycle are legal, and no result is dropped or duplicated.

Test Plan:
- Defaults, in_signed=1, RNE, in_int=0xFFFFF884 (-1916) → out_fp=0xC4EF8000, inexact=0, out_valid exactly 3 cycles after accept.
- Defaults, unsigned, in_int=0xFFFFFFFF → RNE 0x4F800000 with inexact=1; RTZ 0x4F7FFFFF with inexact=1. Signed 0x80000000 → 0xCF000000, exact.
- Tie cases, unsigned in_int=0x01000001 → RNE 0x4B800000, RUP 0x4B800001, RDN 0x4B800000. in_int=0x01000003 under RNE → 0x4B800002. inexact=1 in all cases.
- Zero input and back-to-back stream:
  - in_int=0 → 0x00000000 with flags 0.
  - Stream 8 operands on consecutive cycles → 8 results in order on consecutive cycles.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full → in_ready=0 and out_fp stable. Release → remaining results drain in order, none lost.
- INT_W=16, EXP_W=5, MAN_W=10, unsigned in_int=0xFFFF:
  - RNE → 0x7C00, overflow=1.
  - RTZ → 0x7BFF.
  - Assert reset mid-stream → out_valid drops to 0 immediately, and no stale result appears afterwards.
